// File: rtl/mem_pkg.sv
// Shared constants, state encoding and helpers
// for the data memory controller.
package mem_pkg;

  localparam logic [4:0] OP_PUSH = 5'b01100;
  localparam logic [4:0] OP_POP  = 5'b01101;
  localparam logic [4:0] OP_STD  = 5'b01110;
  localparam logic [4:0] OP_LDD  = 5'b01111;

  localparam logic [10:0] SP_RESET_DEF = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // ops = {push, pop, ldd, std}
  function automatic logic is_onehot(
    input logic [3:0] ops
  );
    return (ops != 4'b0) &&
           ((ops & (ops - 4'd1)) == 4'b0);
  endfunction

  function automatic logic [4:0] enc_op(
    input logic [3:0] ops
  );
    logic [4:0] r;
    r = OP_STD;
    unique case (1'b1)
      ops[3]:  r = OP_PUSH;
      ops[2]:  r = OP_POP;
      ops[1]:  r = OP_LDD;
      default: r = OP_STD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with inc/dec/hold
// and empty/full indications.
module stack_pointer #(
  parameter int unsigned ADDR_W = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic              at_empty,
  output logic              at_full
);

  // inc wins over dec; both are never set together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= SP_RESET;
    else if (inc) sp <= sp + 1'b1;
    else if (dec) sp <= sp - 1'b1;
  end

  assign at_empty = (sp == SP_RESET);
  assign at_full  = (sp == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage responder: PUSH/POP/LDD/STD
// against a fixed-latency synchronous RAM.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 11,
  parameter logic [ADDR_W-1:0] SP_RESET =
    ADDR_W'(SP_RESET_DEF),
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              op_push,
  input  logic              op_pop,
  input  logic              op_ldd,
  input  logic              op_std,
  input  logic [ADDR_W-1:0] ea,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] sp,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              err_ill,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] LAT_M1 =
    2'(MEM_LAT - 1);

  state_t            state;
  logic [4:0]        op_q;
  logic [1:0]        cnt;
  logic              flushed;
  logic              rsp_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] rdata_q;
  logic              at_empty;
  logic              at_full;
  logic              sp_inc;
  logic              sp_dec;
  logic [3:0]        ops;
  logic              accept;
  logic              is_wr;

  assign ops    = {op_push, op_pop, op_ldd, op_std};
  assign accept = req_valid & req_ready;
  assign is_wr  = (op_q == OP_PUSH) ||
                  (op_q == OP_STD);

  assign sp_dec = (state == S_ISSUE) &&
                  (op_q == OP_PUSH);
  assign sp_inc = (state == S_ISSUE) &&
                  (op_q == OP_POP);

  stack_pointer #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .at_empty (at_empty),
    .at_full  (at_full)
  );

  // A flush in RESP must still hide the
  // response, so the last cycle is gated.
  assign rsp_valid = rsp_q & ~flush;
  assign rdata     = rsp_valid ? cap_q : rdata_q;

  // Request FSM, RAM drive and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      op_q      <= '0;
      cnt       <= '0;
      flushed   <= 1'b0;
      rsp_q     <= 1'b0;
      cap_q     <= '0;
      rdata_q   <= '0;
      done      <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_ill   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done   <= 1'b0;
      rsp_q  <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_onehot(ops)) begin
              err_ill <= 1'b1;
              done    <= 1'b1;
            end else if (op_push && at_full) begin
              err_ovf <= 1'b1;
              done    <= 1'b1;
            end else if (op_pop && at_empty) begin
              err_unf <= 1'b1;
              done    <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              req_ready <= 1'b0;
              op_q      <= enc_op(ops);
              flushed   <= 1'b0;
              mem_en    <= 1'b1;
              mem_we    <= op_push | op_std;
              mem_wdata <= wdata;
              mem_addr  <= op_push ? sp :
                           op_pop  ? sp + 1'b1 :
                                     ea;
            end
          end
        end
        S_ISSUE: begin
          if (is_wr) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            done      <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        S_WAIT: begin
          flushed <= flushed | flush;
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state <= S_RESP;
            done  <= 1'b1;
            if (!(flushed || flush)) begin
              rsp_q <= 1'b1;
              cap_q <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          if (rsp_valid) rdata_q <= cap_q;
        end
      endcase
    end
  end

endmodule
